// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between a logic unit, the result buffer and its consumer.
// master drives the upstream result and downstream ready; slave is the buffer.
interface alu_result_buffer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_parity;

    modport master (
        output in_valid, in_result, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_neg, out_parity
    );

    modport slave (
        input  in_valid, in_result, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_neg, out_parity
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Registered output FIFO for the bitwise logic units: stores result plus
// zero/neg/parity flags computed at capture, and counts delivered results.
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    alu_result_buffer_if.slave         bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = WIDTH + 3;

    logic [EW-1:0] r_mem [DEPTH];
    logic [EW-1:0] r_last;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [15:0]   r_count;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    assign w_in_ready  = !reset && (r_level != LW'(DEPTH));
    assign w_out_valid = (r_level != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Flags are frozen alongside the result so the output never recomputes them.
    assign w_entry = {bus.in_result,
                      ~|bus.in_result,
                      bus.in_result[WIDTH-1],
                      ^bus.in_result};

    // When empty, present the most recently retired entry instead of stale slots.
    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : r_last;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = w_head[EW-1:3];
    assign bus.out_zero   = w_head[2];
    assign bus.out_neg    = w_head[1];
    assign bus.out_parity = w_head[0];
    assign level          = r_level;
    assign count          = r_count;

    // Storage, pointers, occupancy and delivered-result counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_last   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed-vector bench for alu_result_buffer with hand-computed expectations.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_result_buffer;
    logic        clk;
    logic        reset;
    logic [1:0]  level;
    logic [15:0] count;
    int          n_run;
    int          n_fail;

    alu_result_buffer_if #(.WIDTH(32)) bus ();

    alu_result_buffer #(.WIDTH(32), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .level (level),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] r,
                            input logic z, input logic n, input logic p);
        chk({tag, ".valid"},  64'(bus.out_valid), 64'd1);
        chk({tag, ".result"}, 64'(bus.out_result), 64'(r));
        chk({tag, ".zero"},   64'(bus.out_zero), 64'(z));
        chk({tag, ".neg"},    64'(bus.out_neg), 64'(n));
        chk({tag, ".parity"}, 64'(bus.out_parity), 64'(p));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        n_run  = 0;
        n_fail = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst.in_ready",  64'(bus.in_ready), 64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.result",    64'(bus.out_result), 64'd0);
        chk("rst.flags",     64'({bus.out_zero, bus.out_neg, bus.out_parity}), 64'd0);
        chk("rst.level",     64'(level), 64'd0);
        chk("rst.count",     64'(count), 64'd0);
        reset = 1'b0;
        #1;
        chk("idle.in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("idle.count",     64'(count), 64'd0);
        chk("idle.out_valid", 64'(bus.out_valid), 64'd0);

        a = 32'h5555_5555;
        b = 32'hAAAA_AAAA;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = a ^ b;
        tick();
        bus.in_valid = 1'b0;
        chk_head("ones", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("ones.level", 64'(level), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("ones.count",     64'(count), 64'd1);
        chk("ones.level0",    64'(level), 64'd0);
        chk("ones.out_valid", 64'(bus.out_valid), 64'd0);
        chk("ones.hold",      64'(bus.out_result), 64'hFFFF_FFFF);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h0;
        tick();
        bus.in_result = 32'h1;
        tick();
        chk("full.level",    64'(level), 64'd2);
        chk("full.in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_result = 32'h1234_5678;
        tick();
        chk("full.level_hold", 64'(level), 64'd2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk_head("full.h0", 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_head("full.h1", 32'h1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("full.drained", 64'(level), 64'd0);
        chk("full.count",   64'(count), 64'd3);
        chk("full.hold",    64'(bus.out_result), 64'd1);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = 32'(i);
            tick();
            chk("stream.result", 64'(bus.out_result), 64'(i));
            chk("stream.valid",  64'(bus.out_valid), 64'd1);
            chk("stream.level",  64'(level), 64'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream.count", 64'(count), 64'd13);
        chk("stream.level0", 64'(level), 64'd0);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'hA1;
        tick();
        bus.in_result = 32'hB2;
        tick();
        chk("sim.level2", 64'(level), 64'd2);
        bus.in_result = 32'hC3;
        bus.out_ready = 1'b1;
        tick();
        chk("sim.full_level", 64'(level), 64'd1);
        chk("sim.full_head",  64'(bus.out_result), 64'hB2);
        tick();
        chk("sim.l1_level", 64'(level), 64'd1);
        chk("sim.l1_head",  64'(bus.out_result), 64'hC3);
        bus.in_valid = 1'b0;
        tick();
        chk("sim.level0", 64'(level), 64'd0);
        chk("sim.count",  64'(count), 64'd16);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h11;
        tick();
        bus.in_result = 32'h22;
        tick();
        bus.in_valid = 1'b0;
        chk("pre.level", 64'(level), 64'd2);
        reset = 1'b1;
        tick();
        chk("mid.level",     64'(level), 64'd0);
        chk("mid.count",     64'(count), 64'd0);
        chk("mid.out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid.result",    64'(bus.out_result), 64'd0);
        chk("mid.in_ready",  64'(bus.in_ready), 64'd0);
        reset = 1'b0;
        tick();
        chk("post.out_valid", 64'(bus.out_valid), 64'd0);
        chk("post.result",    64'(bus.out_result), 64'd0);
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h8000_0033;
        tick();
        bus.in_valid = 1'b0;
        chk_head("post.h", 32'h8000_0033, 1'b0, 1'b1, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        chk("post.count", 64'(count), 64'd1);
        chk("post.level", 64'(level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage directly downstream of the 32-bit bitwise logic units (XOR_32 and its siblings) in the vALU datapath. Captures each combinational result, computes zero, negative and parity flags at capture time, and holds result and flags in a small FIFO behind a valid/ready handshake. The ALU output thereby becomes a clean registered boundary for the consumer (register-file writeback or test harness). A saturating counter of delivered results supports bench bookkeeping.

## Interface
- `WIDTH`, 32: result width in bits; flags derive from this width.
- `DEPTH`, 2: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  upstream result on `in_result` is valid this cycle.
- `in_ready`  out  1  buffer can accept this cycle.
- `in_result`  in  WIDTH  combinational result from the logic unit (e.g. XOR_32 `O`).
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes head entry this cycle.
- `out_result`  out  WIDTH  head entry result.
- `out_zero`  out  1  head result == 0.
- `out_neg`  out  1  head result bit WIDTH-1.
- `out_parity`  out  1  XOR-reduction of head result (1 = odd number of ones).
- `level`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `count`  out  16  number of results popped since reset; saturates at 0xFFFF.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `{in_result, zero, neg, parity}` into the tail entry; flags are computed from `in_result` in the same cycle and stored, never recomputed at the output.
- Pop: `out_valid && out_ready` at a rising edge retires the head entry and increments `count` (unless already 0xFFFF).
- `in_ready` = `!reset && (level != DEPTH)`; it depends only on registered state, never on `out_ready` (no combinational ready path through the buffer).
- `out_valid` = `(level != 0)`; `out_result`/flags reflect head entry; undefined-free: when empty they hold the last popped value (0 after reset).
- Push and pop in the same cycle: both occur; `level` unchanged; order preserved.
- Full (`level == DEPTH`): `in_ready` low; `in_valid` ignored; pop that cycle frees a slot usable from the next cycle.
- Empty: `out_valid` low; `out_ready` ignored; `count` unchanged.
- Read/write pointers are log2(DEPTH)-bit and wrap modulo DEPTH; `level` tracked separately.
- Reset (at any time, including mid-transfer): next edge clears pointers, `level` = 0, `count` = 0, stored entries and all outputs to 0; `in_ready` low while `reset` high, high the first cycle after.
- Upstream must hold `in_result` stable while `in_valid && !in_ready`; the buffer imposes no other protocol rule.

## Timing
- Reset values: `in_ready` 0 (during reset) then 1, `out_valid` 0, `out_result` 0, `out_zero` 0, `out_neg` 0, `out_parity` 0, `level` 0, `count` 0.
- Latency: result pushed at edge N appears on `out_*` with `out_valid` high in the cycle after edge N (1 cycle); no same-cycle fall-through.
- Throughput: one push and one pop per cycle sustained when `out_ready` held high.
- `level` and `count` update on the same edge as the push/pop that changes them.

## Test plan
- Reset then idle: all outputs 0, `in_ready` 1 one cycle after `reset` drops; `out_ready` high with empty buffer leaves `count` 0.
- Push 0xFFFFFFFF (XOR of 0x55555555/0xAAAAAAAA) -> next cycle `out_valid` 1, `out_result` 0xFFFFFFFF, `out_zero` 0, `out_neg` 1, `out_parity` 0; pop -> `count` 1, `level` 0.
- Push 0x00000000 then 0x00000001 with `out_ready` low -> `level` 2, `in_ready` 0; third push of 0x12345678 ignored; pops yield 0 (`zero` 1) then 1 (`parity` 1, `neg` 0), never 0x12345678.
- Streaming: 10 consecutive pushes of 0,1,..,9 with `out_ready` high -> outputs 0..9 in order, each one cycle after its push, `level` stays 1, `count` 10.
- Simultaneous push/pop at full (pop releases slot, push blocked that cycle) and at level 1 (both occur, `level` stays 1) -> order preserved across pointer wrap.
- Assert `reset` with `level` 2 and `count` 5 -> next edge `level` 0, `count` 0, `out_valid` 0; pre-reset entries never reappear.
